// File: rtl/avst_mmio_pkg.sv
// avst_mmio_pkg
// Shared types and constants for the CCI-P MMIO-to-Avalon converter.
// The packed command struct is the same layout the upstream converter
// produces: {is_read, is_32bit, addr, write_data} from MSB to LSB.
package avst_mmio_pkg;

    localparam int CMD_ADDR_WIDTH = 16;
    localparam int CMD_DATA_WIDTH = 64;

    typedef struct packed {
        logic                      is_read;
        logic                      is_32bit;
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [CMD_DATA_WIDTH-1:0] write_data;
    } t_avst_mmio_cmd;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } t_state;

    localparam logic [7:0] BE_FULL = 8'hFF;
    localparam logic [7:0] BE_LO   = 8'h0F;
    localparam logic [7:0] BE_HI   = 8'hF0;

    // A 32-bit access targets the upper or lower word of the 8-byte lane
    // depending on address bit 2; 64-bit accesses enable every byte.
    function automatic logic [7:0] calc_byteenable(input logic is_32bit,
                                                   input logic upper_word);
        logic [7:0] be;
        if (!is_32bit) begin
            be = BE_FULL;
        end else if (upper_word) begin
            be = BE_HI;
        end else begin
            be = BE_LO;
        end
        return be;
    endfunction

endpackage

// File: rtl/avst_mmio_sync_fifo.sv
// avst_mmio_sync_fifo
// Single-clock show-ahead FIFO: the oldest entry is always visible on head
// (zero when empty) and pop simply advances past it.
// Ports:
//   clk, SoftReset  - clock and asynchronous active-high reset
//   push, push_data - write an entry (ignored when full without a pop)
//   pop             - discard the head entry (ignored when empty)
//   head            - oldest entry, zero while empty
//   count           - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module avst_mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     SoftReset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Forcing zero while empty keeps the downstream data output clean after reset.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avst_mmio_avmm_master.sv
// avst_mmio_avmm_master
// Downstream stage of the CCI-P MMIO-to-Avalon-ST converter. Buffers packed
// commands, issues them in order as pipelined Avalon-MM reads/writes and
// returns 64-bit read data in request order. Reads are only issued while a
// credit is free, so the response buffer can never overflow.
// Ports:
//   clk, SoftReset           - clock, asynchronous active-high reset
//   in_data/valid/ready      - command stream {is_read, is_32bit, addr, wdata}
//   out_data/valid/ready     - read response stream
//   avmm_*                   - Avalon-MM master
// Optional build macro AVMM_MMIO_STATS_EN adds stat_reads, stat_writes and
// stat_stall_cycles counters (32-bit, wrapping).
module avst_mmio_avmm_master
    import avst_mmio_pkg::*;
#(
    parameter int AVMM_ADDR_WIDTH = 16,
    parameter int AVMM_DATA_WIDTH = 64,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int MAX_PENDING     = 16
) (
    input  logic                                     clk,
    input  logic                                     SoftReset,
    input  logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [AVMM_DATA_WIDTH-1:0]               out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [AVMM_ADDR_WIDTH-1:0]               avmm_address,
    output logic                                     avmm_read,
    output logic                                     avmm_write,
    output logic [AVMM_DATA_WIDTH-1:0]               avmm_writedata,
    output logic [7:0]                               avmm_byteenable,
    input  logic                                     avmm_waitrequest,
    input  logic [AVMM_DATA_WIDTH-1:0]               avmm_readdata,
    input  logic                                     avmm_readdatavalid
`ifdef AVMM_MMIO_STATS_EN
    ,
    output logic [31:0]                              stat_reads,
    output logic [31:0]                              stat_writes,
    output logic [31:0]                              stat_stall_cycles
`endif
);

    localparam int CMD_W     = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + 2;
    localparam int CMD_CNT_W = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam int PEND_W    = $clog2(MAX_PENDING) + 1;

    logic [CMD_W-1:0]           cmd_head;
    logic [CMD_CNT_W-1:0]       cmd_count;
    logic [CMD_CNT_W-1:0]       cmd_count_next;
    logic                       cmd_push;
    logic                       cmd_pop;
    logic                       cmd_empty;

    logic                       head_is_read;
    logic                       head_is_32bit;
    logic [AVMM_ADDR_WIDTH-1:0] head_addr;
    logic [AVMM_DATA_WIDTH-1:0] head_wdata;
    logic                       unused_addr_bits;

    t_state                     state;
    logic                       xfer_done;
    logic                       read_done;
    logic                       head_issuable;
    logic                       load;

    logic [PEND_W-1:0]          pending;
    logic [PEND_W-1:0]          pending_next;
    logic [PEND_W-1:0]          resp_count;
    logic                       resp_push;
    logic                       resp_pop;

    // Command buffer in front of the issue stage.
    assign cmd_push  = in_valid && in_ready;
    assign cmd_pop   = load;
    assign cmd_empty = (cmd_count == '0);

    avst_mmio_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .SoftReset (SoftReset),
        .push      (cmd_push),
        .push_data (in_data),
        .pop       (cmd_pop),
        .head      (cmd_head),
        .count     (cmd_count)
    );

    assign head_is_read  = cmd_head[CMD_W-1];
    assign head_is_32bit = cmd_head[CMD_W-2];
    assign head_addr     = cmd_head[CMD_W-3 -: AVMM_ADDR_WIDTH];
    assign head_wdata    = cmd_head[AVMM_DATA_WIDTH-1:0];

    // Address bits [1:0] never reach the bus; the lane is 8-byte aligned.
    assign unused_addr_bits = ^head_addr[1:0];

    // Occupancy after this edge, used to register in_ready so it drops the
    // moment the buffer becomes full.
    always_comb begin
        cmd_count_next = cmd_count;
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_count_next = cmd_count + CMD_CNT_W'(1);
            2'b01:   cmd_count_next = cmd_count - CMD_CNT_W'(1);
            default: cmd_count_next = cmd_count;
        endcase
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (cmd_count_next != CMD_CNT_W'(CMD_FIFO_DEPTH));
        end
    end

    // Credits cover reads accepted by the slave plus responses still queued.
    // The issue decision looks at the post-edge count so a read finishing
    // this cycle is already charged before the next one is launched.
    assign read_done = avmm_read && !avmm_waitrequest;
    assign resp_pop  = out_valid && out_ready;

    always_comb begin
        pending_next = pending;
        if (read_done && !resp_pop) begin
            pending_next = pending + PEND_W'(1);
        end else if (!read_done && resp_pop) begin
            pending_next = pending - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // A read stuck on credit also blocks every later command, keeping
    // strict arrival order on the bus.
    assign xfer_done     = (state == ISSUE) && !avmm_waitrequest;
    assign head_issuable = !cmd_empty &&
                           (!head_is_read || (pending_next < PEND_W'(MAX_PENDING)));
    assign load          = head_issuable && ((state == IDLE) || xfer_done);

    // Issue stage: loading a command registers every Avalon output; they
    // stay frozen while the slave stalls, and the strobes drop only when
    // nothing issuable is waiting behind a completed transfer.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state           <= IDLE;
            avmm_read       <= 1'b0;
            avmm_write      <= 1'b0;
            avmm_address    <= '0;
            avmm_writedata  <= '0;
            avmm_byteenable <= '0;
        end else if (load) begin
            state           <= ISSUE;
            avmm_read       <= head_is_read;
            avmm_write      <= !head_is_read;
            avmm_address    <= {head_addr[AVMM_ADDR_WIDTH-1:3], 3'b000};
            avmm_writedata  <= head_wdata;
            avmm_byteenable <= calc_byteenable(head_is_32bit, head_addr[2]);
        end else if (xfer_done) begin
            state           <= IDLE;
            avmm_read       <= 1'b0;
            avmm_write      <= 1'b0;
        end
    end

    // Response buffer. Data arriving with no credit outstanding belongs to a
    // read abandoned by reset and is dropped.
    assign resp_push = avmm_readdatavalid && (pending != '0);
    assign out_valid = (resp_count != '0);

    avst_mmio_sync_fifo #(
        .WIDTH (AVMM_DATA_WIDTH),
        .DEPTH (MAX_PENDING)
    ) u_resp_fifo (
        .clk       (clk),
        .SoftReset (SoftReset),
        .push      (resp_push),
        .push_data (avmm_readdata),
        .pop       (resp_pop),
        .head      (out_data),
        .count     (resp_count)
    );

`ifdef AVMM_MMIO_STATS_EN
    // Activity counters; they wrap silently at 2^32.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            stat_reads        <= '0;
            stat_writes       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (read_done) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (avmm_write && !avmm_waitrequest) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if ((state == ISSUE) && avmm_waitrequest) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avst_mmio_avmm_master.sv
// tb_avst_mmio_avmm_master
// Scoreboard bench: accepted commands queue their expected bus transfer,
// accepted reads queue their expected response, and a negedge monitor pops
// and compares whenever the DUT completes a transfer or a response.
module tb_avst_mmio_avmm_master;
    import avst_mmio_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 64;
    localparam int MAXP = 16;

    logic              clk = 1'b0;
    logic              SoftReset;
    logic [AW+DW+1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     avmm_address;
    logic              avmm_read;
    logic              avmm_write;
    logic [DW-1:0]     avmm_writedata;
    logic [7:0]        avmm_byteenable;
    logic              avmm_waitrequest;
    logic [DW-1:0]     avmm_readdata;
    logic              avmm_readdatavalid;
`ifdef AVMM_MMIO_STATS_EN
    logic [31:0]       stat_reads;
    logic [31:0]       stat_writes;
    logic [31:0]       stat_stall_cycles;
`endif

    avst_mmio_avmm_master dut (
        .clk                (clk),
        .SoftReset          (SoftReset),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid)
`ifdef AVMM_MMIO_STATS_EN
        ,
        .stat_reads         (stat_reads),
        .stat_writes        (stat_writes),
        .stat_stall_cycles  (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_read;
        logic [AW-1:0] addr;
        logic [7:0]    be;
        logic [DW-1:0] data;
    } exp_issue_t;

    typedef struct packed {
        logic [DW-1:0] data;
        longint        due;
    } slv_t;

    exp_issue_t    exp_issue[$];
    logic [DW-1:0] exp_resp[$];
    slv_t          slv_q[$];

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint last_due = 0;
    int     reads_issued = 0;
    int     writes_issued = 0;
    int     resp_popped = 0;
    int     stall_obs = 0;
    int     ov_cnt = 0;
    int     rdv_cnt = 0;

    // Slave / sink behaviour knobs
    int            wr_mode = 1;   // 0 random, 1 never stall, 2 always stall
    int            wr_pct = 0;
    int            lat_min = 1;
    int            lat_max = 1;
    int            ordy_mode = 1; // 0 random, 1 always ready, 2 never ready
    logic          fixed_en = 1'b0;
    logic [DW-1:0] fixed_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until the DUT takes it. Entered and
    // left at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic rd, input logic b32,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_avst_mmio_cmd c;
        int waited;
        c.is_read    = rd;
        c.is_32bit   = b32;
        c.addr       = a;
        c.write_data = d;
        in_data  = c;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 500) begin
                reportTimeout("cmd_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Slave and response sink, updated just after each rising edge.
    initial begin
        slv_t s;
        forever begin
            @(posedge clk);
            #2;
            case (wr_mode)
                0:       avmm_waitrequest = ($urandom_range(0, 99) < wr_pct);
                1:       avmm_waitrequest = 1'b0;
                default: avmm_waitrequest = 1'b1;
            endcase
            case (ordy_mode)
                0:       out_ready = ($urandom_range(0, 99) < 70);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
                s = slv_q.pop_front();
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = s.data;
                rdv_cnt++;
            end else begin
                avmm_readdatavalid = 1'b0;
                avmm_readdata      = '0;
            end
        end
    end

    // Monitor / scoreboard.
    t_avst_mmio_cmd mon_cmd;
    exp_issue_t     mon_exp;
    logic           held = 1'b0;
    logic           h_rd, h_wr;
    logic [AW-1:0]  h_addr;
    logic [7:0]     h_be;
    logic [DW-1:0]  h_data;

    always @(negedge clk) begin
        logic [DW-1:0] rdata;
        longint due;
        slv_t s;
        if (SoftReset) begin
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                mon_cmd         = in_data;
                mon_exp.is_read = mon_cmd.is_read;
                mon_exp.addr    = mon_cmd.addr & 16'hFFF8;
                mon_exp.be      = !mon_cmd.is_32bit ? 8'hFF :
                                  (mon_cmd.addr[2] ? 8'hF0 : 8'h0F);
                mon_exp.data    = mon_cmd.write_data;
                exp_issue.push_back(mon_exp);
            end

            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_response: got %h expected none", out_data);
                end else begin
                    checkOutput("resp_data", out_data, exp_resp.pop_front());
                end
                resp_popped++;
            end

            if (held) begin
                checkOutput("hold_strobes", {avmm_read, avmm_write}, {h_rd, h_wr});
                checkOutput("hold_address", avmm_address, h_addr);
                checkOutput("hold_be", avmm_byteenable, h_be);
                checkOutput("hold_data", avmm_writedata, h_data);
            end
            held = 1'b0;

            if (avmm_read || avmm_write) begin
                if (avmm_waitrequest) begin
                    stall_obs++;
                    held   = 1'b1;
                    h_rd   = avmm_read;
                    h_wr   = avmm_write;
                    h_addr = avmm_address;
                    h_be   = avmm_byteenable;
                    h_data = avmm_writedata;
                end else begin
                    if (exp_issue.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_issue: got addr %h expected none", avmm_address);
                    end else begin
                        mon_exp = exp_issue.pop_front();
                        checkOutput("issue_kind", {avmm_read, avmm_write},
                                    {mon_exp.is_read, !mon_exp.is_read});
                        checkOutput("issue_address", avmm_address, mon_exp.addr);
                        checkOutput("issue_be", avmm_byteenable, mon_exp.be);
                        if (!mon_exp.is_read)
                            checkOutput("issue_wdata", avmm_writedata, mon_exp.data);
                    end
                    if (avmm_read) begin
                        reads_issued++;
                        rdata = fixed_en ? fixed_data : {$urandom, $urandom};
                        due = cyc + longint'($urandom_range(lat_min, lat_max));
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        s.data = rdata;
                        s.due  = due;
                        slv_q.push_back(s);
                        exp_resp.push_back(rdata);
                        checkOutput("credit_bound", 64'(reads_issued - resp_popped <= MAXP), 64'd1);
                    end else begin
                        writes_issued++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_r, base_p, base_ov, base_w, base_rdv, acc, waited;
        logic rdy;
        SoftReset          = 1'b1;
        in_valid           = 1'b0;
        in_data            = '0;
        out_ready          = 1'b0;
        avmm_waitrequest   = 1'b0;
        avmm_readdata      = '0;
        avmm_readdatavalid = 1'b0;

        // Reset state
        waitCycles(3);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_avmm_read", avmm_read, 0);
        checkOutput("rst_avmm_write", avmm_write, 0);
        checkOutput("rst_byteenable", avmm_byteenable, 0);
        SoftReset = 1'b0;
        #1;
        checkOutput("in_ready_before_edge", in_ready, 0);
        waitCycles(1);
        checkOutput("in_ready_after_edge", in_ready, 1);

        // 64-bit write, no stall, no response
        $display("[TB] 64-bit write");
        base_ov = ov_cnt;
        base_w  = writes_issued;
        applyStimulus(1'b0, 1'b0, 16'h0010, 64'h1122334455667788);
        waitCycles(10);
        checkOutput("write_issued", 64'(writes_issued - base_w), 1);
        checkOutput("write_no_response", 64'(ov_cnt - base_ov), 0);

        // 32-bit read from upper word, slave answers 3 cycles later
        $display("[TB] 32-bit read");
        lat_min = 3; lat_max = 3; fixed_en = 1'b1; fixed_data = 64'hAAAABBBBCCCCDDDD;
        base_p  = resp_popped;
        base_ov = ov_cnt;
        applyStimulus(1'b1, 1'b1, 16'h0024, 64'h0);
        waited = 0;
        while (resp_popped == base_p && waited < 100) begin waitCycles(1); waited++; end
        if (waited >= 100) reportTimeout("read_response");
        waitCycles(3);
        checkOutput("read_ov_cycles", 64'(ov_cnt - base_ov), 1);
        fixed_en = 1'b0;

        // Write held off by five waitrequest cycles
        $display("[TB] stalled write");
        wr_mode   = 2;
        stall_obs = 0;
        base_w    = writes_issued;
        applyStimulus(1'b0, 1'b1, 16'h0104, 64'hDEADBEEFDEADBEEF);
        waited = 0;
        while (stall_obs < 5 && waited < 100) begin waitCycles(1); waited++; end
        if (waited >= 100) reportTimeout("stall_count");
        wr_mode = 1;
        waitCycles(4);
        checkOutput("stall_cycles", 64'(stall_obs), 5);
        checkOutput("stalled_write_done", 64'(writes_issued - base_w), 1);

        // Credit limit: 20 reads with the response side blocked
        $display("[TB] credit limit");
        ordy_mode = 2; lat_min = 1; lat_max = 1;
        waitCycles(1);
        base_r = reads_issued;
        base_p = resp_popped;
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 64'h0);
        waitCycles(20);
        checkOutput("credit_issued", 64'(reads_issued - base_r), 16);
        checkOutput("credit_out_valid", out_valid, 1);
        ordy_mode = 1;
        waited = 0;
        while (resp_popped - base_p < 20 && waited < 300) begin waitCycles(1); waited++; end
        if (waited >= 300) reportTimeout("credit_drain");
        checkOutput("credit_all_issued", 64'(reads_issued - base_r), 20);
        checkOutput("credit_all_returned", 64'(resp_popped - base_p), 20);

        // Back-pressure: slave stalls forever, in_valid held high
        $display("[TB] command backpressure");
        wr_mode = 2;
        waitCycles(1);
        acc = 0;
        in_data  = {1'b0, 1'b0, 16'h0200, 64'h0};
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc++;
                in_data = {1'b0, 1'b0, 16'(16'h0200 + 16'(acc * 8)), 64'(acc)};
            end
        end
        in_valid = 1'b0;
        checkOutput("accepts_under_stall", 64'(acc), 5);
        checkOutput("in_ready_when_full", in_ready, 0);
        wr_mode = 1;
        waited = 0;
        while (exp_issue.size() > 0 && waited < 100) begin waitCycles(1); waited++; end
        if (waited >= 100) reportTimeout("backpressure_drain");
        checkOutput("backpressure_lost", 64'(exp_issue.size()), 0);

        // Reset with three reads outstanding; late data must be dropped
        $display("[TB] reset mid-operation");
        lat_min = 30; lat_max = 30;
        base_r = reads_issued;
        applyStimulus(1'b1, 1'b0, 16'h0108, 64'h0);
        applyStimulus(1'b1, 1'b1, 16'h0234, 64'h0);
        applyStimulus(1'b1, 1'b1, 16'h0348, 64'h0);
        waited = 0;
        while (reads_issued - base_r < 3 && waited < 50) begin waitCycles(1); waited++; end
        if (waited >= 50) reportTimeout("reset_reads_issue");
        #2;
        SoftReset = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_out_data", out_data, 0);
        checkOutput("mid_rst_strobes", {avmm_read, avmm_write}, 0);
        checkOutput("mid_rst_address", avmm_address, 0);
        checkOutput("mid_rst_wdata", avmm_writedata, 0);
        checkOutput("mid_rst_be", avmm_byteenable, 0);
        exp_issue.delete();
        exp_resp.delete();
        reads_issued = 0;
        resp_popped  = 0;
        waitCycles(2);
        SoftReset = 1'b0;
        base_ov  = ov_cnt;
        base_rdv = rdv_cnt;
        waitCycles(45);
        checkOutput("late_rdv_delivered", 64'(rdv_cnt - base_rdv), 3);
        checkOutput("late_rdv_dropped", 64'(ov_cnt - base_ov), 0);

        // Randomized traffic
        $display("[TB] random traffic");
        wr_mode = 0; wr_pct = 30; lat_min = 1; lat_max = 6; ordy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom), {$urandom, $urandom});
            waitCycles($urandom_range(0, 2));
        end
        wr_mode = 1; ordy_mode = 1;
        waited = 0;
        while ((exp_issue.size() > 0 || exp_resp.size() > 0 || slv_q.size() > 0 || out_valid)
               && waited < 2000) begin
            waitCycles(1);
            waited++;
        end
        if (waited >= 2000) reportTimeout("random_drain");
        checkOutput("final_issue_queue", 64'(exp_issue.size()), 0);
        checkOutput("final_resp_queue", 64'(exp_resp.size()), 0);
        checkOutput("final_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
